// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // True when DIGITS decimal digits can represent every WIDTH-bit unsigned value.
    function automatic bit digits_sufficient(input int width, input int digits);
        longint pow10;
        longint max_bin;
        pow10   = 1;
        max_bin = (longint'(1) << width) - 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One BCD digit correction step: a digit of 5 or more gets 3 added before the shift.
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with registered
// BCD digits and leading-zero blank flags for downstream 7-segment decoders.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_bin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]           out_blank
);

    localparam int                BCD_W     = BCD_DIGIT_W * DIGITS;
    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS - 1){1'b1}}, 1'b0};

    generate
        if (WIDTH < 4) begin : g_bad_width
            $error("bin_to_bcd_seq: WIDTH must be at least 4");
        end
        if (!digits_sufficient(WIDTH, DIGITS)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BCD_W-1:0]  out_bcd_q, out_bcd_d;
    logic [DIGITS-1:0] out_blank_q, out_blank_d;

    logic [BCD_W-1:0]  work_adj;
    logic [BCD_W-1:0]  work_shl;
    logic [DIGITS-1:0] blank_new;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_dabble_digit u_digit (
                .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign work_shl = {work_adj[BCD_W-2:0], shift_q[WIDTH-1]};

    // Blank flags look at the result being committed this edge, not the old output.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_new  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (work_shl[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_new[i] = zero_above;
        end
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        shift_d     = shift_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_blank_d = out_blank_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_bin;
                    work_d  = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = work_shl;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_bcd_d   = work_shl;
                    out_blank_d = blank_new;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_blank_q <= BLANK_RST;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_blank_q <= out_blank_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_blank = out_blank_q;

endmodule
